id_stage: RTL and testbench

- Registered, parametrised decode stage for the RV64 pipeline, sitting between instruction fetch and EX.
- Generalises the combinational decoder in four ways:
  - N-source GPR/CSR forwarding network, configurable by parameter.
  - Load-use hazard detection with stall.
  - valid/ready handshakes on both sides, plus flush.
  - Fully sign-extended XLEN immediates, so no width-select flag is needed downstream.
- Output is a single pipeline register: one decoded instruction held in flight.

---
 rtl/id_pkg.sv | 82 ++++++++
 rtl/id_stage_fwd_select.sv | 52 +++++
 rtl/id_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_pkg
//  Description : Shared decode definitions for the RV64 ID stage: major
//                opcodes, load/store funct3 codes, access-length encoding,
//                immediate-format enum, output-buffer state enum and the
//                immediate extraction helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

   // Major opcodes (inst[6:0])
   localparam logic [6:0] c_opc_r      = 7'b0110011;
   localparam logic [6:0] c_opc_i      = 7'b0010011;
   localparam logic [6:0] c_opc_load   = 7'b0000011;
   localparam logic [6:0] c_opc_store  = 7'b0100011;
   localparam logic [6:0] c_opc_branch = 7'b1100011;
   localparam logic [6:0] c_opc_lui    = 7'b0110111;
   localparam logic [6:0] c_opc_auipc  = 7'b0010111;
   localparam logic [6:0] c_opc_jal    = 7'b1101111;
   localparam logic [6:0] c_opc_jalr   = 7'b1100111;
   localparam logic [6:0] c_opc_system = 7'b1110011;

   // Load/store funct3 codes
   localparam logic [2:0] c_f3_b  = 3'b000;
   localparam logic [2:0] c_f3_h  = 3'b001;
   localparam logic [2:0] c_f3_w  = 3'b010;
   localparam logic [2:0] c_f3_d  = 3'b011;
   localparam logic [2:0] c_f3_bu = 3'b100;
   localparam logic [2:0] c_f3_hu = 3'b101;
   localparam logic [2:0] c_f3_wu = 3'b110;

   // Dcache access length; equals funct3[1:0] of the load/store
   localparam logic [1:0] c_wlen_byte   = 2'd0;
   localparam logic [1:0] c_wlen_half   = 2'd1;
   localparam logic [1:0] c_wlen_word   = 2'd2;
   localparam logic [1:0] c_wlen_double = 2'd3;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } obuf_state_e;

   function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
      case (opcode)
         c_opc_i, c_opc_load,
         c_opc_jalr, c_opc_system: return IMM_I;
         c_opc_store:              return IMM_S;
         c_opc_branch:             return IMM_B;
         c_opc_lui, c_opc_auipc:   return IMM_U;
         c_opc_jal:                return IMM_J;
         default:                  return IMM_NONE;
      endcase
   endfunction

   // Immediate sign-extended to 32 bits; the caller widens it to XLEN.
   // Only inst[31:7] carries immediate bits.
   function automatic logic [31:0] imm32(input logic [31:7] inst,
                                         input imm_type_e    t);
      case (t)
         IMM_I:   return {{20{inst[31]}}, inst[31:20]};
         IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                          inst[11:8], 1'b0};
         IMM_U:   return {inst[31:12], 12'b0};
         IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                          inst[30:21], 1'b0};
         default: return 32'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_select
//  Description : Priority forwarding mux. Source 0 has the highest priority;
//                the first enabled source whose address matches supplies the
//                data and its pending flag, otherwise the base (register
//                file) data is passed through with pending low. With
//                ZERO_REG set, address 0 always reads zero and never pends.
//  Ports       : i_addr        operand address being read
//                i_base_data   register-file / CSR-file read data
//                i_src_wen     per-source write enable
//                i_src_addr    per-source destination address (packed)
//                i_src_data    per-source write data (packed)
//                i_src_pending per-source "data not ready yet"
//                o_data        selected operand
//                o_pending     winning source is still pending
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_select #(
   parameter int XLEN     = 64,
   parameter int AW       = 5,
   parameter int N        = 3,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic [AW-1:0]     i_addr,
   input  logic [XLEN-1:0]   i_base_data,
   input  logic [N-1:0]      i_src_wen,
   input  logic [AW*N-1:0]   i_src_addr,
   input  logic [XLEN*N-1:0] i_src_data,
   input  logic [N-1:0]      i_src_pending,
   output logic [XLEN-1:0]   o_data,
   output logic              o_pending
);

   // Walk from the lowest priority up so the youngest match is applied last.
   always_comb begin
      o_data    = i_base_data;
      o_pending = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_src_wen[i] && (i_src_addr[i*AW +: AW] == i_addr)) begin
            o_data    = i_src_data[i*XLEN +: XLEN];
            o_pending = i_src_pending[i];
         end
      end
      if (ZERO_REG && (i_addr == '0)) begin
         o_data    = '0;
         o_pending = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Registered RV64 decode stage. Decodes the fetch beat,
//                forwards GPR/CSR operands, detects load-use hazards,
//                builds the XLEN immediate and the dcache request, and holds
//                one decoded bundle in an output register with valid/ready
//                handshakes on both sides plus flush.
//  Ports       : clk, rst (async, active-low)
//                fetch side : if_valid_i, if_ready_o, inst_i, pc_i, flush_i
//                regfile    : rs1/rs2_addr_o, rs1/rs2_data_i
//                CSR file   : csr_raddr_o, csr_data_i
//                forwarding : fwd_*_i (GPR), csr_fwd_*_i (CSR)
//                EX side    : ex_valid_o, ex_ready_i and the registered
//                             bundle (opcode .. pc_o)
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage
   import id_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int ADDR_W    = 64,
   parameter int N_FWD     = 3,
   parameter int N_CSR_FWD = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   if_valid_i,
   output logic                   if_ready_o,
   input  logic [31:0]            inst_i,
   input  logic [ADDR_W-1:0]      pc_i,
   output logic [4:0]             rs1_addr_o,
   output logic [4:0]             rs2_addr_o,
   input  logic [XLEN-1:0]        rs1_data_i,
   input  logic [XLEN-1:0]        rs2_data_i,
   output logic [11:0]            csr_raddr_o,
   input  logic [XLEN-1:0]        csr_data_i,
   input  logic [N_FWD-1:0]       fwd_wreg_i,
   input  logic [5*N_FWD-1:0]     fwd_rd_addr_i,
   input  logic [XLEN*N_FWD-1:0]  fwd_wdata_i,
   input  logic [N_FWD-1:0]       fwd_pending_i,
   input  logic [N_CSR_FWD-1:0]   csr_fwd_wreg_i,
   input  logic [12*N_CSR_FWD-1:0] csr_fwd_waddr_i,
   input  logic [XLEN*N_CSR_FWD-1:0] csr_fwd_wdata_i,
   output logic                   ex_valid_o,
   input  logic                   ex_ready_i,
   output logic [6:0]             opcode_o,
   output logic [2:0]             funct3_o,
   output logic [6:0]             funct7_o,
   output logic [XLEN-1:0]        rs1_data_o,
   output logic [XLEN-1:0]        rs2_data_o,
   output logic [XLEN-1:0]        csr_data_o,
   output logic [4:0]             rd_addr_o,
   output logic [11:0]            csr_waddr_o,
   output logic                   wreg_o,
   output logic                   csr_wreg_o,
   output logic [XLEN-1:0]        imm_o,
   output logic                   dcache_req_valid_o,
   output logic                   dcache_wen_o,
   output logic [XLEN-1:0]        dcache_wdata_o,
   output logic [ADDR_W-1:0]      dcache_addr_o,
   output logic [1:0]             dcache_wlen_o,
   output logic [ADDR_W-1:0]      pc_o
);

   // ------------------------------------------------------------------
   // Field extraction
   // ------------------------------------------------------------------
   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [11:0] w_csr_addr;

   assign w_opcode   = inst_i[6:0];
   assign w_rd       = inst_i[11:7];
   assign w_funct3   = inst_i[14:12];
   assign w_rs1      = inst_i[19:15];
   assign w_rs2      = inst_i[24:20];
   assign w_funct7   = inst_i[31:25];
   assign w_csr_addr = inst_i[31:20];

   assign rs1_addr_o  = w_rs1;
   assign rs2_addr_o  = w_rs2;
   assign csr_raddr_o = w_csr_addr;

   logic w_is_load;
   logic w_is_store;
   logic w_is_branch;
   logic w_rs1_used;
   logic w_rs2_used;

   assign w_is_load   = (w_opcode == c_opc_load);
   assign w_is_store  = (w_opcode == c_opc_store);
   assign w_is_branch = (w_opcode == c_opc_branch);
   assign w_rs1_used  = !((w_opcode == c_opc_lui) || (w_opcode == c_opc_auipc) ||
                          (w_opcode == c_opc_jal));
   assign w_rs2_used  = (w_opcode == c_opc_r) || w_is_store || w_is_branch;

   // ------------------------------------------------------------------
   // Immediate, sign-extended to XLEN
   // ------------------------------------------------------------------
   imm_type_e        w_imm_type;
   logic [31:0]      w_imm32;
   logic [XLEN-1:0]  w_imm;

   assign w_imm_type = imm_type_of(w_opcode);
   assign w_imm32    = imm32(inst_i[31:7], w_imm_type);

   generate
      if (XLEN > 32) begin : g_imm_sext
         assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
      end else begin : g_imm_direct
         assign w_imm = w_imm32[XLEN-1:0];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Operand forwarding
   // ------------------------------------------------------------------
   logic [XLEN-1:0] w_rs1_fwd;
   logic [XLEN-1:0] w_rs2_fwd;
   logic [XLEN-1:0] w_csr_fwd;
   logic            w_rs1_pend;
   logic            w_rs2_pend;
   logic            w_csr_pend;

   fwd_select #(
      .XLEN     (XLEN),
      .AW       (5),
      .N        (N_FWD),
      .ZERO_REG (1'b1)
   ) u_fwd_rs1 (
      .i_addr        (w_rs1),
      .i_base_data   (rs1_data_i),
      .i_src_wen     (fwd_wreg_i),
      .i_src_addr    (fwd_rd_addr_i),
      .i_src_data    (fwd_wdata_i),
      .i_src_pending (fwd_pending_i),
      .o_data        (w_rs1_fwd),
      .o_pending     (w_rs1_pend)
   );

   fwd_select #(
      .XLEN     (XLEN),
      .AW       (5),
      .N        (N_FWD),
      .ZERO_REG (1'b1)
   ) u_fwd_rs2 (
      .i_addr        (w_rs2),
      .i_base_data   (rs2_data_i),
      .i_src_wen     (fwd_wreg_i),
      .i_src_addr    (fwd_rd_addr_i),
      .i_src_data    (fwd_wdata_i),
      .i_src_pending (fwd_pending_i),
      .o_data        (w_rs2_fwd),
      .o_pending     (w_rs2_pend)
   );

   // CSR sources have no pending notion; their pending inputs are tied low
   // so the CSR path can never raise the hazard.
   fwd_select #(
      .XLEN     (XLEN),
      .AW       (12),
      .N        (N_CSR_FWD),
      .ZERO_REG (1'b0)
   ) u_fwd_csr (
      .i_addr        (w_csr_addr),
      .i_base_data   (csr_data_i),
      .i_src_wen     (csr_fwd_wreg_i),
      .i_src_addr    (csr_fwd_waddr_i),
      .i_src_data    (csr_fwd_wdata_i),
      .i_src_pending ({N_CSR_FWD{1'b0}}),
      .o_data        (w_csr_fwd),
      .o_pending     (w_csr_pend)
   );

   logic w_hazard;
   assign w_hazard = (w_rs1_used && w_rs1_pend) || (w_rs2_used && w_rs2_pend) ||
                     w_csr_pend;

   // ------------------------------------------------------------------
   // Dcache request
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] w_dc_addr;
   logic [1:0]        w_wlen;
   logic [XLEN-1:0]   w_store_wdata;

   generate
      if (ADDR_W <= XLEN) begin : g_addr_trunc
         assign w_dc_addr = ADDR_W'(w_rs1_fwd) + ADDR_W'(w_imm);
      end else begin : g_addr_zext
         assign w_dc_addr = {{(ADDR_W-XLEN){1'b0}}, w_rs1_fwd + w_imm};
      end
   endgenerate

   assign w_wlen = w_funct3[1:0];

   // Store data carries only the accessed bytes; everything above is zero.
   always_comb begin
      w_store_wdata = '0;
      if (w_is_store) begin
         case (w_wlen)
            c_wlen_byte:   w_store_wdata = XLEN'(w_rs2_fwd[7:0]);
            c_wlen_half:   w_store_wdata = XLEN'(w_rs2_fwd[15:0]);
            c_wlen_word:   w_store_wdata = XLEN'(w_rs2_fwd[31:0]);
            default:       w_store_wdata = w_rs2_fwd;
         endcase
      end
   end

   logic w_wreg;
   logic w_csr_wreg;

   assign w_wreg     = !(w_is_store || w_is_branch) && (w_rd != 5'd0);
   assign w_csr_wreg = (w_opcode == c_opc_system) && (w_funct3 != 3'd0);

   // ------------------------------------------------------------------
   // Output register control
   // ------------------------------------------------------------------
   obuf_state_e r_state;
   obuf_state_e w_state_next;
   logic        w_valid;
   logic        w_if_ready;
   logic        w_load;
   logic        w_drain;

   assign w_valid    = (r_state == ST_FULL);
   assign w_if_ready = !flush_i && !w_hazard && (!w_valid || ex_ready_i);
   assign w_load     = if_valid_i && w_if_ready;
   assign w_drain    = w_valid && ex_ready_i;

   assign if_ready_o = w_if_ready;
   assign ex_valid_o = w_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_EMPTY: if (w_load) w_state_next = ST_FULL;
         ST_FULL:  if (w_drain && !w_load) w_state_next = ST_EMPTY;
         default:  w_state_next = ST_EMPTY;
      endcase
      // load already excludes flush, so this only overrides hold/refill
      if (flush_i) begin
         w_state_next = ST_EMPTY;
      end
   end

   // ------------------------------------------------------------------
   // Bundle register: written only on an accepted fetch beat
   // ------------------------------------------------------------------
   logic [6:0]        r_opcode;
   logic [2:0]        r_funct3;
   logic [6:0]        r_funct7;
   logic [XLEN-1:0]   r_rs1_data;
   logic [XLEN-1:0]   r_rs2_data;
   logic [XLEN-1:0]   r_csr_data;
   logic [4:0]        r_rd_addr;
   logic [11:0]       r_csr_waddr;
   logic              r_wreg;
   logic              r_csr_wreg;
   logic [XLEN-1:0]   r_imm;
   logic              r_dc_req;
   logic              r_dc_wen;
   logic [XLEN-1:0]   r_dc_wdata;
   logic [ADDR_W-1:0] r_dc_addr;
   logic [1:0]        r_dc_wlen;
   logic [ADDR_W-1:0] r_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_opcode    <= '0;
         r_funct3    <= '0;
         r_funct7    <= '0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_csr_data  <= '0;
         r_rd_addr   <= '0;
         r_csr_waddr <= '0;
         r_wreg      <= 1'b0;
         r_csr_wreg  <= 1'b0;
         r_imm       <= '0;
         r_dc_req    <= 1'b0;
         r_dc_wen    <= 1'b0;
         r_dc_wdata  <= '0;
         r_dc_addr   <= '0;
         r_dc_wlen   <= '0;
         r_pc        <= '0;
      end else if (w_load) begin
         r_opcode    <= w_opcode;
         r_funct3    <= w_funct3;
         r_funct7    <= w_funct7;
         r_rs1_data  <= w_rs1_fwd;
         r_rs2_data  <= w_rs2_fwd;
         r_csr_data  <= w_csr_fwd;
         r_rd_addr   <= w_rd;
         r_csr_waddr <= w_csr_addr;
         r_wreg      <= w_wreg;
         r_csr_wreg  <= w_csr_wreg;
         r_imm       <= w_imm;
         r_dc_req    <= w_is_load || w_is_store;
         r_dc_wen    <= w_is_store;
         r_dc_wdata  <= w_store_wdata;
         r_dc_addr   <= w_dc_addr;
         r_dc_wlen   <= w_wlen;
         r_pc        <= pc_i;
      end
   end

   assign opcode_o           = r_opcode;
   assign funct3_o           = r_funct3;
   assign funct7_o           = r_funct7;
   assign rs1_data_o         = r_rs1_data;
   assign rs2_data_o         = r_rs2_data;
   assign csr_data_o         = r_csr_data;
   assign rd_addr_o          = r_rd_addr;
   assign csr_waddr_o        = r_csr_waddr;
   assign wreg_o             = r_wreg;
   assign csr_wreg_o         = r_csr_wreg;
   assign imm_o              = r_imm;
   assign dcache_req_valid_o = r_dc_req;
   assign dcache_wen_o       = r_dc_wen;
   assign dcache_wdata_o     = r_dc_wdata;
   assign dcache_addr_o      = r_dc_addr;
   assign dcache_wlen_o      = r_dc_wlen;
   assign pc_o               = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Self-checking bench for id_stage. A behavioural model of the
//                decode rules and the one-entry output buffer is compared
//                against the DUT every cycle; directed scenarios add literal
//                expectations for reset, forwarding priority, load-use,
//                backpressure, stores, CSR forwarding, flush and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

   localparam int XLEN = 64;
   localparam int AW   = 64;
   localparam int NF   = 3;
   localparam int NC   = 3;

   logic clk = 1'b0;
   logic rst;
   logic flush_i, if_valid_i, ex_ready_i;
   logic [31:0] inst_i;
   logic [AW-1:0] pc_i;
   logic if_ready_o, ex_valid_o;
   logic [4:0] rs1_addr_o, rs2_addr_o;
   logic [XLEN-1:0] rs1_data_i, rs2_data_i, csr_data_i;
   logic [11:0] csr_raddr_o;
   logic [NF-1:0] fwd_wreg_v, fwd_pend_v;
   logic [5*NF-1:0] fwd_addr_v;
   logic [XLEN*NF-1:0] fwd_data_v;
   logic [NC-1:0] cfwd_wreg_v;
   logic [12*NC-1:0] cfwd_addr_v;
   logic [XLEN*NC-1:0] cfwd_data_v;
   logic [6:0] opcode_o, funct7_o;
   logic [2:0] funct3_o;
   logic [XLEN-1:0] rs1_data_o, rs2_data_o, csr_data_o, imm_o, dcache_wdata_o;
   logic [4:0] rd_addr_o;
   logic [11:0] csr_waddr_o;
   logic wreg_o, csr_wreg_o, dcache_req_valid_o, dcache_wen_o;
   logic [AW-1:0] dcache_addr_o, pc_o;
   logic [1:0] dcache_wlen_o;

   // bench-side register file, CSR value and forwarding sources
   logic [63:0] rf [32];
   logic [63:0] csr_base;
   logic        f_wen [NF];
   logic [4:0]  f_addr[NF];
   logic [63:0] f_data[NF];
   logic        f_pend[NF];
   logic        c_wen [NC];
   logic [11:0] c_addr[NC];
   logic [63:0] c_data[NC];

   always_comb begin
      for (int i = 0; i < NF; i++) begin
         fwd_wreg_v[i]           = f_wen[i];
         fwd_pend_v[i]           = f_pend[i];
         fwd_addr_v[i*5 +: 5]    = f_addr[i];
         fwd_data_v[i*64 +: 64]  = f_data[i];
      end
      for (int i = 0; i < NC; i++) begin
         cfwd_wreg_v[i]          = c_wen[i];
         cfwd_addr_v[i*12 +: 12] = c_addr[i];
         cfwd_data_v[i*64 +: 64] = c_data[i];
      end
   end

   assign rs1_data_i = rf[rs1_addr_o];
   assign rs2_data_i = rf[rs2_addr_o];
   assign csr_data_i = csr_base;

   id_stage #(.XLEN(XLEN), .ADDR_W(AW), .N_FWD(NF), .N_CSR_FWD(NC)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
      .inst_i(inst_i), .pc_i(pc_i),
      .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .csr_raddr_o(csr_raddr_o), .csr_data_i(csr_data_i),
      .fwd_wreg_i(fwd_wreg_v), .fwd_rd_addr_i(fwd_addr_v),
      .fwd_wdata_i(fwd_data_v), .fwd_pending_i(fwd_pend_v),
      .csr_fwd_wreg_i(cfwd_wreg_v), .csr_fwd_waddr_i(cfwd_addr_v),
      .csr_fwd_wdata_i(cfwd_data_v),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
      .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
      .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .csr_data_o(csr_data_o),
      .rd_addr_o(rd_addr_o), .csr_waddr_o(csr_waddr_o),
      .wreg_o(wreg_o), .csr_wreg_o(csr_wreg_o), .imm_o(imm_o),
      .dcache_req_valid_o(dcache_req_valid_o), .dcache_wen_o(dcache_wen_o),
      .dcache_wdata_o(dcache_wdata_o), .dcache_addr_o(dcache_addr_o),
      .dcache_wlen_o(dcache_wlen_o), .pc_o(pc_o)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [11:0] csrw;
      logic        wreg;
      logic        cwreg;
      logic [63:0] imm;
      logic [63:0] pc;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic [63:0] csr;
      logic        use1;
      logic        use2;
      logic        req;
      logic        wen;
      logic [63:0] addr;
      logic [1:0]  wlen;
      logic [63:0] wdata;
      logic        hz;
   } exp_t;

   function automatic void gpr_read(input logic [4:0] a, output logic [63:0] d, output logic p);
      d = rf[a];
      p = 1'b0;
      if (a == 5'd0) d = 64'd0;
      else begin
         for (int i = 0; i < NF; i++) begin
            if (f_wen[i] && f_addr[i] == a) begin
               d = f_data[i];
               p = f_pend[i];
               break;
            end
         end
      end
   endfunction

   function automatic logic [63:0] csr_read(input logic [11:0] a);
      for (int i = 0; i < NC; i++)
         if (c_wen[i] && c_addr[i] == a) return c_data[i];
      return csr_base;
   endfunction

   function automatic exp_t decode();
      exp_t e;
      logic [31:0] in;
      logic p1, p2;
      in = inst_i;
      e = '0;
      e.opc = in[6:0]; e.f3 = in[14:12]; e.f7 = in[31:25];
      e.rd = in[11:7]; e.csrw = in[31:20]; e.pc = pc_i;
      case (e.opc)
         7'h13, 7'h03, 7'h67, 7'h73: e.imm = {{52{in[31]}}, in[31:20]};
         7'h23: e.imm = {{52{in[31]}}, in[31:25], in[11:7]};
         7'h63: e.imm = {{51{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
         7'h37, 7'h17: e.imm = {{32{in[31]}}, in[31:12], 12'b0};
         7'h6F: e.imm = {{43{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
         default: e.imm = 64'd0;
      endcase
      e.use1 = !(e.opc == 7'h37 || e.opc == 7'h17 || e.opc == 7'h6F);
      e.use2 = (e.opc == 7'h33 || e.opc == 7'h23 || e.opc == 7'h63);
      gpr_read(in[19:15], e.rs1, p1);
      gpr_read(in[24:20], e.rs2, p2);
      e.csr = csr_read(in[31:20]);
      e.hz = (e.use1 && p1) || (e.use2 && p2);
      e.req = (e.opc == 7'h03 || e.opc == 7'h23);
      e.wen = (e.opc == 7'h23);
      e.addr = e.rs1 + e.imm;
      e.wlen = e.f3[1:0];
      case (e.wlen)
         2'd0: e.wdata = e.rs2 & 64'hFF;
         2'd1: e.wdata = e.rs2 & 64'hFFFF;
         2'd2: e.wdata = e.rs2 & 64'hFFFF_FFFF;
         default: e.wdata = e.rs2;
      endcase
      e.wreg = !(e.opc == 7'h23 || e.opc == 7'h63) && (e.rd != 5'd0);
      e.cwreg = (e.opc == 7'h73) && (e.f3 != 3'd0);
      return e;
   endfunction

   logic m_valid;
   exp_t m_b;

   function automatic logic model_ready();
      exp_t e;
      e = decode();
      return !flush_i && !e.hz && (!m_valid || ex_ready_i);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid <= 1'b0;
         m_b     <= '0;
      end else if (flush_i) begin
         m_valid <= 1'b0;
      end else if (if_valid_i && model_ready()) begin
         m_valid <= 1'b1;
         m_b     <= decode();
      end else if (m_valid && ex_ready_i) begin
         m_valid <= 1'b0;
      end
   end

   // compare process: DUT vs model, sampled on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            check("m_if_ready", if_ready_o, model_ready());
            check("m_rs1_addr", rs1_addr_o, inst_i[19:15]);
            check("m_rs2_addr", rs2_addr_o, inst_i[24:20]);
            check("m_csr_raddr", csr_raddr_o, inst_i[31:20]);
            check("m_ex_valid", ex_valid_o, m_valid);
            if (m_valid) begin
               check("m_opcode", opcode_o, m_b.opc);
               check("m_funct3", funct3_o, m_b.f3);
               check("m_funct7", funct7_o, m_b.f7);
               check("m_rd", rd_addr_o, m_b.rd);
               check("m_csr_waddr", csr_waddr_o, m_b.csrw);
               check("m_wreg", wreg_o, m_b.wreg);
               check("m_csr_wreg", csr_wreg_o, m_b.cwreg);
               check("m_imm", imm_o, m_b.imm);
               check("m_pc", pc_o, m_b.pc);
               check("m_csr_data", csr_data_o, m_b.csr);
               if (m_b.use1) check("m_rs1_data", rs1_data_o, m_b.rs1);
               if (m_b.use2) check("m_rs2_data", rs2_data_o, m_b.rs2);
               check("m_dc_req", dcache_req_valid_o, m_b.req);
               check("m_dc_wen", dcache_wen_o, m_b.wen);
               if (m_b.req) begin
                  check("m_dc_addr", dcache_addr_o, m_b.addr);
                  check("m_dc_wlen", dcache_wlen_o, m_b.wlen);
               end
               if (m_b.wen) check("m_dc_wdata", dcache_wdata_o, m_b.wdata);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // present a beat and hold it until the model says it was taken
   task automatic issue(input logic [31:0] in, input logic [63:0] pc);
      logic acc;
      logic done;
      done = 1'b0;
      inst_i = in;
      pc_i = pc;
      if_valid_i = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         acc = model_ready();
         step();
         done = acc;
      end
      if (!done) check("issue_timeout", 64'd0, 64'd1);
      if_valid_i = 1'b0;
   endtask

   localparam logic [31:0] I_ADDI_M1 = 32'hFFF00293; // addi x5,x0,-1
   localparam logic [31:0] I_ADDI_X7 = 32'h00038413; // addi x8,x7,0
   localparam logic [31:0] I_ADD     = 32'h002380B3; // add  x1,x7,x2
   localparam logic [31:0] I_LUI_A   = 32'h12345537; // lui  x10,0x12345
   localparam logic [31:0] I_LUI_B   = 32'h80000537; // lui  x10,0x80000
   localparam logic [31:0] I_SH      = 32'hFE321F23; // sh   x3,-2(x4)
   localparam logic [31:0] I_LD      = 32'h00823483; // ld   x9,8(x4)
   localparam logic [31:0] I_BEQ     = 32'h00208863; // beq  x1,x2,16
   localparam logic [31:0] I_JAL     = 32'hFFDFF0EF; // jal  x1,-4
   localparam logic [31:0] I_CSRRW   = 32'h30029373; // csrrw x6,0x300,x5

   logic [31:0] stream [6];

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; flush_i = 1'b0; if_valid_i = 1'b0; ex_ready_i = 1'b1;
      inst_i = 32'h0; pc_i = '0; csr_base = 64'h5555;
      for (int i = 0; i < 32; i++) rf[i] = 64'h1000_0000 + 64'(i);
      for (int i = 0; i < NF; i++) begin
         f_wen[i] = 1'b0; f_addr[i] = '0; f_data[i] = '0; f_pend[i] = 1'b0;
      end
      for (int i = 0; i < NC; i++) begin
         c_wen[i] = 1'b0; c_addr[i] = '0; c_data[i] = '0;
      end

      // reset
      repeat (3) @(negedge clk);
      check("rst_ex_valid", ex_valid_o, 64'd0);
      check("rst_imm", imm_o, 64'd0);
      check("rst_pc", pc_o, 64'd0);
      check("rst_wreg", wreg_o, 64'd0);
      check("rst_dc_addr", dcache_addr_o, 64'd0);
      step();
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_ex_valid", ex_valid_o, 64'd0);
      check("post_rst_rs1_data", rs1_data_o, 64'd0);
      step();

      // first beat
      issue(I_ADDI_M1, 64'h100);
      @(negedge clk);
      check("addi_valid", ex_valid_o, 64'd1);
      check("addi_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi_wreg", wreg_o, 64'd1);
      check("addi_rd", rd_addr_o, 64'd5);
      step();

      // forwarding priority
      f_wen[0] = 1'b1; f_addr[0] = 5'd7; f_data[0] = 64'h11;
      f_wen[2] = 1'b1; f_addr[2] = 5'd7; f_data[2] = 64'h22;
      issue(I_ADDI_X7, 64'h104);
      @(negedge clk);
      check("fwd_prio0", rs1_data_o, 64'h11);
      step();
      f_wen[0] = 1'b0;
      issue(I_ADDI_X7, 64'h108);
      @(negedge clk);
      check("fwd_prio2", rs1_data_o, 64'h22);
      step();
      f_wen[2] = 1'b0;

      // load-use hazard
      issue(I_ADDI_M1, 64'h10C);
      f_wen[0] = 1'b1; f_addr[0] = 5'd7; f_data[0] = 64'h99; f_pend[0] = 1'b1;
      inst_i = I_ADD; pc_i = 64'h110; if_valid_i = 1'b1;
      @(negedge clk);
      check("lu_ready_low", if_ready_o, 64'd0);
      step();
      @(negedge clk);
      check("lu_bubble", ex_valid_o, 64'd0);
      step();
      f_pend[0] = 1'b0;
      @(negedge clk);
      check("lu_ready_back", if_ready_o, 64'd1);
      step();
      if_valid_i = 1'b0;
      @(negedge clk);
      check("lu_valid", ex_valid_o, 64'd1);
      check("lu_rs1", rs1_data_o, 64'h99);
      check("lu_rs2", rs2_data_o, 64'h1000_0002);
      step();
      f_wen[0] = 1'b0;

      // backpressure then back-to-back refill
      issue(I_LUI_A, 64'h200);
      ex_ready_i = 1'b0;
      inst_i = I_LUI_B; pc_i = 64'h204; if_valid_i = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check("bp_valid", ex_valid_o, 64'd1);
         check("bp_imm", imm_o, 64'h0000_0000_1234_5000);
         check("bp_ready", if_ready_o, 64'd0);
         step();
      end
      ex_ready_i = 1'b1;
      @(negedge clk);
      check("b2b_ready", if_ready_o, 64'd1);
      step();
      if_valid_i = 1'b0;
      @(negedge clk);
      check("b2b_valid", ex_valid_o, 64'd1);
      check("b2b_imm", imm_o, 64'hFFFF_FFFF_8000_0000);
      check("b2b_pc", pc_o, 64'h204);
      step();

      // store
      rf[4] = 64'h1000; rf[3] = 64'hABCD_1234;
      issue(I_SH, 64'h300);
      @(negedge clk);
      check("sh_addr", dcache_addr_o, 64'hFFE);
      check("sh_wdata", dcache_wdata_o, 64'h1234);
      check("sh_wlen", dcache_wlen_o, 64'd1);
      check("sh_wen", dcache_wen_o, 64'd1);
      check("sh_wreg", wreg_o, 64'd0);
      step();

      // load, branch, jal
      issue(I_LD, 64'h304);
      @(negedge clk);
      check("ld_addr", dcache_addr_o, 64'h1008);
      check("ld_wlen", dcache_wlen_o, 64'd3);
      check("ld_req", dcache_req_valid_o, 64'd1);
      check("ld_wen", dcache_wen_o, 64'd0);
      step();
      issue(I_BEQ, 64'h308);
      @(negedge clk);
      check("beq_imm", imm_o, 64'd16);
      check("beq_wreg", wreg_o, 64'd0);
      step();
      issue(I_JAL, 64'h30C);
      @(negedge clk);
      check("jal_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
      check("jal_wreg", wreg_o, 64'd1);
      step();

      // CSR forwarding priority
      c_wen[1] = 1'b1; c_addr[1] = 12'h300; c_data[1] = 64'hCAFE;
      c_wen[2] = 1'b1; c_addr[2] = 12'h300; c_data[2] = 64'hBEEF;
      issue(I_CSRRW, 64'h310);
      @(negedge clk);
      check("csr_data", csr_data_o, 64'hCAFE);
      check("csr_wreg", csr_wreg_o, 64'd1);
      check("csr_waddr", csr_waddr_o, 64'h300);
      step();
      c_wen[1] = 1'b0; c_wen[2] = 1'b0;

      // flush while full with a beat offered
      issue(I_ADDI_M1, 64'h400);
      flush_i = 1'b1; inst_i = I_ADD; pc_i = 64'h404; if_valid_i = 1'b1;
      @(negedge clk);
      check("flush_ready", if_ready_o, 64'd0);
      step();
      flush_i = 1'b0; if_valid_i = 1'b0;
      @(negedge clk);
      check("flush_empty", ex_valid_o, 64'd0);
      step();

      // back-to-back stream
      stream[0] = I_ADDI_M1; stream[1] = I_LD; stream[2] = I_SH;
      stream[3] = I_ADD; stream[4] = I_JAL; stream[5] = I_BEQ;
      for (int i = 0; i < 6; i++) issue(stream[i], 64'h600 + 64'(4 * i));
      step();

      // reset while holding a bundle
      ex_ready_i = 1'b0;
      issue(I_LUI_A, 64'h500);
      rst = 1'b0;
      #1;
      check("midrst_valid", ex_valid_o, 64'd0);
      check("midrst_imm", imm_o, 64'd0);
      step();
      rst = 1'b1; ex_ready_i = 1'b1;
      @(negedge clk);
      check("midrst_after", ex_valid_o, 64'd0);
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
